// File: rtl/sample_capture_buffer_if.sv
// Bundle of the sample-in, block-stream-out and status signals of the capture buffer.
// The buffer itself uses the slave modport. The sample source and the stream consumer
// together use the master modport.
interface sample_capture_buffer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int OVR_WIDTH  = 16
);
    logic                  capture_en_i;
    logic [DATA_WIDTH-1:0] sample_i;
    logic                  sample_valid_i;
    logic                  ram_buffer_ready_o;
    logic [DATA_WIDTH-1:0] ram_read_data_o;
    logic                  ram_read_valid_o;
    logic                  ram_read_ready_i;
    logic [OVR_WIDTH-1:0]  overrun_cnt_o;
    logic                  state_o;

    modport master (
        output capture_en_i, sample_i, sample_valid_i, ram_read_ready_i,
        input  ram_buffer_ready_o, ram_read_data_o, ram_read_valid_o, overrun_cnt_o, state_o
    );

    modport slave (
        input  capture_en_i, sample_i, sample_valid_i, ram_read_ready_i,
        output ram_buffer_ready_o, ram_read_data_o, ram_read_valid_o, overrun_cnt_o, state_o
    );
endinterface

// File: rtl/sample_capture_buffer.sv
// Block-capture RAM. It fills BUFFER_DEPTH samples, then streams them out in write order
// over a valid/ready port. A two-entry skid register sits behind the synchronous RAM read
// port, so a consumer that keeps ready high gets one sample per clock.
// Samples that arrive while the block drains are dropped and counted.
module sample_capture_buffer #(
    parameter int DATA_WIDTH   = 24,
    parameter int BUFFER_DEPTH = 256,
    parameter int OVR_WIDTH    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sample_capture_buffer_if.slave bus
);
    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]        DEPTH_C   = CW'(BUFFER_DEPTH);
    localparam logic [CW-1:0]        LAST_CNT  = CW'(BUFFER_DEPTH - 1);
    localparam logic [AW-1:0]        LAST_ADDR = AW'(BUFFER_DEPTH - 1);
    localparam logic [OVR_WIDTH-1:0] OVR_MAX   = '1;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                 state_q;
    logic [AW-1:0]          wr_ptr_q;
    logic [CW-1:0]          rd_cnt_q;      // RAM reads issued in this block
    logic [CW-1:0]          xfer_cnt_q;    // handshakes completed in this block
    logic                   rd_pend_q;     // RAM output register holds a fresh word
    logic [DATA_WIDTH-1:0]  ram_q;
    logic [DATA_WIDTH-1:0]  mem [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0]  skid_head_q;
    logic [DATA_WIDTH-1:0]  skid_tail_q;
    logic [1:0]             skid_cnt_q;
    logic [OVR_WIDTH-1:0]   ovr_q;

    logic       wr_en;
    logic       rd_en;
    logic       out_valid;
    logic       xfer;
    logic       last_xfer;
    logic [2:0] occ_after;

    assign wr_en     = (state_q == ST_FILL) && bus.capture_en_i && bus.sample_valid_i;
    assign out_valid = (skid_cnt_q != 2'd0);
    assign xfer      = out_valid && bus.ram_read_ready_i;
    assign last_xfer = xfer && (xfer_cnt_q == LAST_CNT);
    // Words that the skid register will hold after this edge, counting the one in flight.
    // A new read is issued only when the skid register is guaranteed a free slot.
    assign occ_after = {1'b0, skid_cnt_q} + {2'b0, rd_pend_q} - {2'b0, xfer};
    assign rd_en     = (state_q == ST_DRAIN) && (rd_cnt_q != DEPTH_C) && (occ_after <= 3'd1);

    assign bus.ram_buffer_ready_o = (state_q == ST_DRAIN);
    assign bus.state_o            = (state_q == ST_DRAIN);
    assign bus.ram_read_valid_o   = out_valid;
    assign bus.ram_read_data_o    = skid_head_q;
    assign bus.overrun_cnt_o      = ovr_q;

    // Sample storage: write port in FILL, registered read port in DRAIN. No reset, so it maps to block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.sample_i;
        end
        if (rd_en) begin
            ram_q <= mem[rd_cnt_q[AW-1:0]];
        end
    end

    // FILL/DRAIN control, pointers and the saturating overrun counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            xfer_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            ovr_q      <= '0;
        end else begin
            rd_pend_q <= rd_en;
            case (state_q)
                ST_FILL: begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        if (wr_ptr_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A sample in DRAIN is dropped whatever capture_en_i is.
                    // This includes the edge of the final transfer.
                    if (bus.sample_valid_i && (ovr_q != OVR_MAX)) begin
                        ovr_q <= ovr_q + 1'b1;
                    end
                    if (rd_en) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                    if (xfer) begin
                        xfer_cnt_q <= xfer_cnt_q + 1'b1;
                    end
                    if (last_xfer) begin
                        state_q    <= ST_FILL;
                        rd_cnt_q   <= '0;
                        xfer_cnt_q <= '0;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    // Two-entry skid register. The head drives the output port. The tail absorbs the word
    // that is still in flight from the RAM when the consumer stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_head_q <= '0;
            skid_tail_q <= '0;
            skid_cnt_q  <= 2'd0;
        end else begin
            case ({rd_pend_q, xfer})
                2'b10: begin
                    if (skid_cnt_q == 2'd0) begin
                        skid_head_q <= ram_q;
                    end else begin
                        skid_tail_q <= ram_q;
                    end
                    skid_cnt_q <= skid_cnt_q + 2'd1;
                end
                2'b01: begin
                    skid_head_q <= skid_tail_q;
                    skid_cnt_q  <= skid_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt_q == 2'd1) begin
                        skid_head_q <= ram_q;
                    end else begin
                        skid_head_q <= skid_tail_q;
                        skid_tail_q <= ram_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sample_capture_buffer.sv
// Self-checking bench for sample_capture_buffer.
// A predictor tracks the block contents, the FILL/DRAIN state and the overrun count from
// the stimulus, and pushes each full block into a scoreboard.
// A separate monitor pops the scoreboard on every handshake and checks that stalled
// outputs hold steady.
module tb_sample_capture_buffer;
    localparam int DW    = 24;
    localparam int DEPTH = 256;
    localparam int OW    = 4;
    localparam int OVR_SAT = (1 << OW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_capture_buffer_if #(.DATA_WIDTH(DW), .OVR_WIDTH(OW)) bus ();

    sample_capture_buffer #(
        .DATA_WIDTH  (DW),
        .BUFFER_DEPTH(DEPTH),
        .OVR_WIDTH   (OW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] fill_q[$];
    bit  m_drain = 0;
    int  m_left = 0;
    int  m_ovr = 0;
    int  m_xfers = 0;
    int  drain_cyc = 0;
    bit  seen_valid = 0;
    int  cyc = 0;
    int  first_xfer_cyc = 0;
    int  last_xfer_cyc = 0;
    bit  full_rate_chk = 0;
    int  blocks_done = 0;
    int  rdy_mode = 2;          // 0: always ready, 1: random 50%, 2: held low

    // Consumer ready driver
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.ram_read_ready_i = 1'b1;
            1:       bus.ram_read_ready_i = 1'($urandom_range(0, 1));
            default: bus.ram_read_ready_i = 1'b0;
        endcase
    end

    // Predictor: compare state and overrun, then advance the model over the coming edge.
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            tests++;
            if (bus.ram_buffer_ready_o !== m_drain || bus.state_o !== m_drain) begin
                fails++;
                $display("[TB] FAIL state: buffer_ready=%0b state=%0b expected %0b (cycle %0d)",
                         bus.ram_buffer_ready_o, bus.state_o, m_drain, cyc);
            end
            tests++;
            if (bus.overrun_cnt_o !== OW'(m_ovr)) begin
                fails++;
                $display("[TB] FAIL overrun: got %0d expected %0d (cycle %0d)", bus.overrun_cnt_o, m_ovr, cyc);
            end
            if (!m_drain) begin
                tests++;
                if (bus.ram_read_valid_o !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL valid_in_fill: got %0b expected 0 (cycle %0d)", bus.ram_read_valid_o, cyc);
                end
                if (bus.capture_en_i && bus.sample_valid_i) begin
                    fill_q.push_back(bus.sample_i);
                    if (fill_q.size() == DEPTH) begin
                        foreach (fill_q[k]) exp_q.push_back(fill_q[k]);
                        fill_q.delete();
                        m_drain    = 1;
                        m_left     = DEPTH;
                        m_xfers    = 0;
                        drain_cyc  = 0;
                        seen_valid = 0;
                    end
                end
            end else begin
                if (bus.ram_read_valid_o === 1'b1 && !seen_valid) begin
                    seen_valid = 1;
                    tests++;
                    if (drain_cyc > 2) begin
                        fails++;
                        $display("[TB] FAIL valid_latency: got %0d cycles expected <= 2", drain_cyc);
                    end
                end
                drain_cyc++;
                if (bus.sample_valid_i && m_ovr < OVR_SAT) m_ovr++;
                if (bus.ram_read_valid_o === 1'b1 && bus.ram_read_ready_i) begin
                    if (m_xfers == 0) first_xfer_cyc = cyc;
                    m_xfers++;
                    m_left--;
                    if (m_left == 0) begin
                        last_xfer_cyc = cyc;
                        m_drain = 0;
                        blocks_done++;
                        $display("[TB] block %0d drained: %0d transfers, overrun=%0d",
                                 blocks_done, m_xfers, m_ovr);
                        if (full_rate_chk) begin
                            tests++;
                            if (last_xfer_cyc - first_xfer_cyc != DEPTH - 1) begin
                                fails++;
                                $display("[TB] FAIL burst_span: got %0d cycles expected %0d",
                                         last_xfer_cyc - first_xfer_cyc, DEPTH - 1);
                            end
                        end
                    end
                end
            end
        end
    end

    // Monitor: scoreboard pop on handshake, stability while stalled
    bit            stall = 0;
    logic [DW-1:0] stall_data;
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            stall = 0;
        end else begin
            if (stall) begin
                tests++;
                if (bus.ram_read_valid_o !== 1'b1 || bus.ram_read_data_o !== stall_data) begin
                    fails++;
                    $display("[TB] FAIL hold: valid=%0b data=%06h expected valid=1 data=%06h",
                             bus.ram_read_valid_o, bus.ram_read_data_o, stall_data);
                end
            end
            if (bus.ram_read_valid_o === 1'b1 && bus.ram_read_ready_i) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL extra_xfer: got data %06h expected no transfer", bus.ram_read_data_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.ram_read_data_o !== e) begin
                        fails++;
                        $display("[TB] FAIL data: got %06h expected %06h", bus.ram_read_data_o, e);
                    end
                end
                stall = 0;
            end else if (bus.ram_read_valid_o === 1'b1) begin
                stall = 1;
                stall_data = bus.ram_read_data_o;
            end else begin
                stall = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        bus.sample_i       = d;
        bus.sample_valid_i = 1'b1;
        tick();
        bus.sample_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (blocks_done < target && n < 5000) begin
            tick();
            n++;
        end
        tests++;
        if (blocks_done < target) begin
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d blocks expected %0d", blocks_done, target);
        end
    endtask

    task automatic check_ovr(input string name, input int want);
        tests++;
        if (bus.overrun_cnt_o !== OW'(want)) begin
            fails++;
            $display("[TB] FAIL %s: got overrun %0d expected %0d", name, bus.overrun_cnt_o, want);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        tests++;
        if (bus.ram_buffer_ready_o !== 1'b0 || bus.ram_read_valid_o !== 1'b0 ||
            bus.ram_read_data_o !== '0 || bus.overrun_cnt_o !== '0 || bus.state_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL %s: got rdy=%0b vld=%0b data=%06h ovr=%0d st=%0b expected all 0", name,
                     bus.ram_buffer_ready_o, bus.ram_read_valid_o, bus.ram_read_data_o,
                     bus.overrun_cnt_o, bus.state_o);
        end
    endtask

    initial begin
        logic [DW-1:0] neg_vals [3];
        logic [DW-1:0] v;
        int n;
        neg_vals[0] = 24'hFFFFFF;
        neg_vals[1] = 24'h800000;
        neg_vals[2] = 24'h800001;
        bus.capture_en_i     = 1'b0;
        bus.sample_i         = '0;
        bus.sample_valid_i   = 1'b0;
        bus.ram_read_ready_i = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset_state");
        rst = 1'b0;
        tick();

        // 1: ramp 1..256 at one sample per 4 clocks, consumer always ready
        rdy_mode = 0;
        full_rate_chk = 1;
        bus.capture_en_i = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            send(DW'(i));
            repeat (3) tick();
        end
        wait_done(1);
        full_rate_chk = 0;

        // 2: negative extremes plus random data, 50% backpressure
        rdy_mode = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 3) send(neg_vals[i]);
            else       send(DW'($urandom()));
        end
        wait_done(2);

        // 4: capture disabled in the middle of a fill
        rdy_mode = 0;
        for (int i = 0; i < 100; i++) send(DW'($urandom()));
        bus.capture_en_i = 1'b0;
        for (int i = 0; i < 50; i++) send(DW'($urandom()));
        bus.capture_en_i = 1'b1;
        for (int i = 0; i < 156; i++) send(DW'($urandom()));
        wait_done(3);
        check_ovr("overrun_after_gated_fill", 0);

        // 3: samples every clock through a 300-clock stalled drain, counter saturates
        rdy_mode = 2;
        for (int i = 0; i < DEPTH; i++) send(DW'($urandom()));
        for (int i = 0; i < 300; i++) send(DW'($urandom()));
        check_ovr("overrun_saturated", OVR_SAT);
        rdy_mode = 1;
        n = 0;
        while (!(blocks_done >= 4 && m_drain) && n < 4000) begin
            send(DW'($urandom()));
            n++;
        end
        wait_done(5);

        // 5: asynchronous reset between edges after 37 transfers
        rdy_mode = 0;
        for (int i = 0; i < DEPTH; i++) send(DW'($urandom()));
        rdy_mode = 1;
        n = 0;
        while (m_xfers < 37 && n < 2000) begin
            tick();
            n++;
        end
        tests++;
        if (m_xfers != 37) begin
            fails++;
            $display("[TB] FAIL reach_37_xfers: got %0d transfers expected 37", m_xfers);
        end
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset_mid_drain");
        exp_q.delete();
        fill_q.delete();
        m_drain = 0;
        m_ovr   = 0;
        m_xfers = 0;
        repeat (2) tick();
        rst = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < DEPTH; i++) send(DW'(24'h100000 + i));
        wait_done(6);

        // 6: consumer-paced constant blocks, no samples offered while the buffer drains
        for (int b = 0; b < 3; b++) begin
            v = (b % 2 == 0) ? DW'(40000) : DW'(-40000);
            for (int i = 0; i < DEPTH; i++) begin
                n = 0;
                while (bus.ram_buffer_ready_o && n < 1000) begin
                    tick();
                    n++;
                end
                send(v);
                tick();
            end
        end
        wait_done(9);
        check_ovr("overrun_paced_blocks", 0);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule
